md_sequencer: RTL

Multiply/divide sequencer for the pipelined MIPS core's E stage. It accepts a mult/div/move-to operation from the E-stage controller, owns the HI/LO register pair, and runs the fixed-latency busy window that the hazard logic turns into D-stage stalls. It is the single owner of the shared multiply/divide resource. It also exposes HI/LO to the E-stage forwarding path for mfhi/mflo.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_arith.sv | 51 +++++
 rtl/md_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and long-op decode.
// MD_MADD_EN makes the madd/msub family (op codes 7-10) long ops; otherwise they decode as NONE.
package md_pkg;

    localparam logic [3:0] OpNone  = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
    localparam logic [3:0] OpMsub  = 4'd9;
    localparam logic [3:0] OpMsubu = 4'd10;

    localparam int unsigned DefaultMultCycles = 5;
    localparam int unsigned DefaultDivCycles  = 10;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        logic long_op;
        long_op = (op == OpMult) || (op == OpMultu) || is_div_op(op);
`ifdef MD_MADD_EN
        long_op = long_op || (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
`endif
        return long_op;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {HI,LO} result for one op.
// MD_MADD_EN adds the accumulate forms; without it those op codes return hilo unchanged.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divisor forced to 1 on zero so the dividers never see x/0; the result is discarded anyway.
    assign div_zero = (b == 32'd0);
    assign div_b    = div_zero ? 32'd1 : b;
    assign quot_s   = $signed(a) / $signed(div_b);
    assign rem_s    = $signed(a) % $signed(div_b);
    assign quot_u   = a / div_b;
    assign rem_u    = a % div_b;

    always_comb begin
        result = hilo;
        case (op)
            OpMult:  result = prod_s;
            OpMultu: result = prod_u;
            OpDiv:   result = {rem_s, quot_s};
            OpDivu:  result = {rem_u, quot_u};
`ifdef MD_MADD_EN
            OpMadd:  result = hilo + prod_s;
            OpMaddu: result = hilo + prod_u;
            OpMsub:  result = hilo - prod_s;
            OpMsubu: result = hilo - prod_u;
`endif
            default: result = hilo;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs the fixed busy window, raises stall_req.
// MD_MADD_EN (decoded in md_pkg::is_long_op) enables the madd/msub family.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefaultMultCycles,
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_ok_q, pend_ok_d;
    logic [63:0] arith_res;
    logic        arith_div_zero;

    md_arith u_arith (
        .op       (md_op),
        .a        (src_a),
        .b        (src_b),
        .hilo     ({hi_q, lo_q}),
        .result   (arith_res),
        .div_zero (arith_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_ok_d = pend_ok_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        pend_d    = arith_res;
                        pend_ok_d = !(is_div_op(md_op) && arith_div_zero);
                        cnt_d     = is_div_op(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        state_d   = StRun;
                    end else if (md_op == OpMthi) begin
                        hi_d = src_a;
                    end else if (md_op == OpMtlo) begin
                        lo_d = src_a;
                    end
                end
            end
            StRun: begin
                // New starts are ignored here; the hazard unit keeps them out via stall_req.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_ok_q) begin
                        {hi_d, lo_d} = pend_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign stall_req = d_is_md & (busy | (start & is_long_op(md_op)));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
